// File: rtl/multiport_ram_pkg.sv
// Shared types and constants for the multi-master word RAM.
// Imported by the top level and the RAM bank.
package multiport_ram_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/multiport_ram_sp_be.sv
// Single-port synchronous word RAM with byte-enabled writes.
// Read data is registered; the array itself is never reset.
module ram_sp_be
  import multiport_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           req,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // A write cycle also loads rdata with the pre-write word; callers ignore it.
  always_ff @(posedge clk) begin
    if (req) begin
      if (we) begin
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/multiport_ram.sv
// Single-bank word RAM shared by several request/grant/rvalid masters,
// with fixed-priority or round-robin arbitration and a 1- or 2-stage response.
module multiport_ram
  import multiport_ram_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter arb_mode_e   ARB_MODE     = ARB_FIXED,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [NUM_PORTS-1:0][3:0]   be_i,
  input  logic [NUM_PORTS-1:0][31:0]  addr_i,
  input  logic [NUM_PORTS-1:0][31:0]  wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [NUM_PORTS-1:0]        err_o,
  output logic [31:0]                 rdata_o
);

  localparam int          NP   = int'(NUM_PORTS);
  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        win_idx;
  logic [NUM_PORTS-1:0] gnt;
  logic                 any_gnt;

  always_comb begin : arbiter
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NP; i++) begin
      if (ARB_MODE == ARB_RR) begin
        // Search upward from the pointer, wrapping modulo the port count.
        sum = {1'b0, rr_ptr} + (PW+1)'(i);
        if (sum >= (PW+1)'(NP)) sum = sum - (PW+1)'(NP);
        idx = sum[PW-1:0];
      end else begin
        idx = PW'(i);
      end
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

  assign gnt_o   = gnt;
  assign any_gnt = |gnt;

  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin : port_mux
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NP; i++) begin
      if (gnt[i]) begin
        sel_we    = we_i[i];
        sel_be    = be_i[i];
        sel_addr  = addr_i[i];
        sel_wdata = wdata_i[i];
      end
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  logic [31:0] offset;
  logic        in_range;

  assign offset   = sel_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);

  logic [31:0] ram_rdata;

  ram_sp_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk  (clk),
    .req  (any_gnt & in_range),
    .we   (sel_we),
    .be   (sel_be),
    .addr (offset[AW+1:2]),
    .wdata(sel_wdata),
    .rdata(ram_rdata)
  );

  logic [PW-1:0] rr_next;
  assign rr_next = (win_idx == PW'(NP - 1)) ? '0 : win_idx + 1'b1;

  // ---- stage p0: access issued, bank output valid ----
  logic [NUM_PORTS-1:0] vld_p0;
  logic                 err_p0;
  logic                 zero_p0;
  logic [31:0]          data_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= '0;
      err_p0  <= 1'b0;
      zero_p0 <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      vld_p0  <= gnt;
      err_p0  <= any_gnt & ~in_range;
      zero_p0 <= ~in_range;
      if (any_gnt) rr_ptr <= rr_next;
    end
  end

  assign data_p0 = zero_p0 ? '0 : ram_rdata;

  // ---- stage p1: optional output register ----
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [NUM_PORTS-1:0] vld_p1;
      logic                 err_p1;
      logic [31:0]          data_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= '0;
          err_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1  <= vld_p0;
          err_p1  <= err_p0;
          data_p1 <= data_p0;
        end
      end

      assign rvalid_o = vld_p1;
      assign err_o    = vld_p1 & {NUM_PORTS{err_p1}};
      assign rdata_o  = data_p1;
    end else begin : g_lat1
      assign rvalid_o = vld_p0;
      assign err_o    = vld_p0 & {NUM_PORTS{err_p0}};
      assign rdata_o  = data_p0;
    end
  endgenerate

endmodule

// File: doc/multiport_ram.md
# multiport_ram

Parametrised single-bank word RAM shared by `NUM_PORTS` Ibex-style request/grant/rvalid masters, e.g. instruction fetch, data port and debug or DMA. Arbitration is selectable: fixed priority or round-robin. The read pipeline depth is configurable, and accesses outside the window complete with an error response. It replaces per-SoC hand-written two-port RAM wrappers in the memory subsystem.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of master ports, 1..8.
- `DEPTH_WORDS`, 4096: RAM depth in 32-bit words, power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `ARB_MODE`, `ARB_FIXED`: `ARB_FIXED` (port 0 highest priority) or `ARB_RR`.
- `READ_LATENCY`, 1: cycles from gnt to rvalid, 1 or 2. Value 2 adds an output register.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `NUM_PORTS`: request per port.
- `we_i`, in, `NUM_PORTS`: write enable per port.
- `be_i`, in, `NUM_PORTS`x4: byte enables per port.
- `addr_i`, in, `NUM_PORTS`x32: byte address per port.
- `wdata_i`, in, `NUM_PORTS`x32: write data per port.
- `gnt_o`, out, `NUM_PORTS`: grant, combinational, one-hot or zero.
- `rvalid_o`, out, `NUM_PORTS`: response valid per port.
- `err_o`, out, `NUM_PORTS`: error, qualified by `rvalid_o`.
- `rdata_o`, out, 32: read data, broadcast to all ports, qualified by `rvalid_o`.

## Operation
- Each cycle at most one requesting port is granted. `gnt_o` is driven the same cycle as `req_i`, and a granted request is consumed that cycle.
- `ARB_FIXED` mode: the lowest-index requesting port wins.
- `ARB_RR` mode:
  - The winner is the first requesting port at or after the priority pointer `rr_ptr`, searching upward modulo `NUM_PORTS`.
  - On any grant, `rr_ptr` is set to winner+1 mod `NUM_PORTS`.
  - With no grant, `rr_ptr` holds.
- In-range test: `addr_i - BASE_ADDR < DEPTH_WORDS*4`, computed as unsigned 32-bit. Word index = `(addr_i - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]`. `addr_i[1:0]` is ignored.
- In-range write: bytes with `be_i` set are written; the others are kept.
- In-range read: returns the full word; `be_i` is ignored.
- Out-of-range access: the request is still granted and the RAM is not accessed.
  - Writes have no effect.
  - The response carries `err_o`=1 and `rdata_o`=0.
- Every grant, read or write, produces exactly one `rvalid_o` pulse on the granted port.
- `NUM_PORTS`=1: the arbiter degenerates to `gnt_o = req_i`.

## Timing
- `rvalid_o[p]` rises exactly `READ_LATENCY` cycles after the cycle in which `gnt_o[p]` was high, for 1 cycle. `err_o[p]` and `rdata_o` are valid in that same cycle.
- Back-to-back grants give back-to-back rvalids. The response pipeline accepts one access per cycle and never stalls.
- Read-during-write is impossible because the bank is single-port. A read following a write to the same word returns the new data.
- Reset values:
  - `rvalid_o`=0, `err_o`=0, `rr_ptr`=0.
  - `rdata_o`=0 when `READ_LATENCY`=2; unspecified when `READ_LATENCY`=1.
  - `gnt_o` follows `req_i` combinationally, even during reset.
- Reset asserted mid-operation:
  - All in-flight responses are dropped; no rvalid appears after reset release.
  - RAM contents are not cleared.
- Pipeline state per stage: one-hot port tag, err bit, zero-data flag.

## Structure
- Package `multiport_ram_pkg`:
  - `arb_mode_e` enum, with values `ARB_FIXED` and `ARB_RR`.
  - `WORD_BYTES` = 4 constant.
- Sub-module `ram_sp_be`: single-port synchronous RAM.
  - Parameter `DEPTH_WORDS`.
  - Ports `clk`, `req`, `we`, `be`, `addr`, `wdata`, `rdata`.
  - Registered read with 1-cycle latency; no reset on the array.
- Top level holds the arbiter, address decode and response pipeline. A separate arbiter module is not required.

## Test plan
- Fixed-priority contention: `NUM_PORTS`=2, `ARB_FIXED`. Both ports read continuously for 4 cycles -> port 0 granted all 4 cycles, port 1 never granted. Port 0 gets 4 consecutive rvalids starting 1 cycle after the first grant.
- Round-robin fairness: `NUM_PORTS`=3, `ARB_RR`, all ports requesting for 6 cycles -> grant order 0,1,2,0,1,2. With only ports 0 and 2 requesting -> grants alternate 0,2,0,2.
- Byte-enable write: write 32'hDEADBEEF with `be`=4'hF to word 5, then 32'h0000_1200 with `be`=4'b0010, then read -> rdata 32'hDEAD12EF.
- Out-of-range access: `BASE_ADDR`=32'h1000, `DEPTH_WORDS`=256.
  - Read 32'h1400 -> granted; after `READ_LATENCY` cycles, `rvalid`=1, `err`=1, `rdata`=0.
  - Write 32'h0FFC -> `err`=1; word 255 is unchanged.
- Latency 2: `READ_LATENCY`=2, reads of words 0..3 on consecutive cycles -> rvalid on cycles t+2..t+5 with matching data, and no gaps.
- Reset mid-flight: assert `rst_n`=0 one cycle after a grant with `READ_LATENCY`=2 -> `rvalid_o` stays 0 through and after reset release, and `rr_ptr` returns to 0.
